// File: rtl/keypad_pkg.sv
// keypad_pkg: shared types and constants for the 4x4 matrix keypad scanner.
//   state_t        debounce FSM states
//   NUM_ROWS/COLS  keypad geometry
//   KEY_W          width of a key code
//   key_code_of()  maps (row, col) to the key code 4*row + col
package keypad_pkg;

    localparam int NUM_ROWS = 4;
    localparam int NUM_COLS = 4;
    localparam int KEY_W    = 4;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        DEBOUNCE = 2'd1,
        PRESSED  = 2'd2,
        RELEASE  = 2'd3
    } state_t;

    // With four columns, 4*row + col is simply {row, col}.
    function automatic logic [KEY_W-1:0] key_code_of(input logic [1:0] row,
                                                     input logic [1:0] col);
        return {row, col};
    endfunction

endpackage

// File: rtl/keypad_scanner_if.sv
// keypad_scanner_if: key-entry bus from the scanner to the operand shifter.
//   key_code     last accepted key code
//   shift_valid  one-cycle strobe per accepted press
//   key_pressed  high while a debounced key is held
// Modports: master (scanner drives), slave (shift-register/adder stage).
interface keypad_scanner_if;
    import keypad_pkg::*;

    logic [KEY_W-1:0] key_code;
    logic             shift_valid;
    logic             key_pressed;

    modport master (output key_code, output shift_valid, output key_pressed);
    modport slave  (input  key_code, input  shift_valid, input  key_pressed);

endinterface

// File: rtl/keypad_col_scan.sv
// keypad_col_scan: column drive timing for the keypad scanner.
//   clk        system clock
//   rst_n      synchronous active-low reset
//   col_out    active-low one-hot column drive
//   col        index of the currently driven column
//   sample_en  high on the last cycle of each column slot (row sample point)
//   scan_end   high on the last cycle of column 3 (full scan complete)
module keypad_col_scan
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV = 1000
) (
    input  logic                clk,
    input  logic                rst_n,
    output logic [NUM_COLS-1:0] col_out,
    output logic [1:0]          col,
    output logic                sample_en,
    output logic                scan_end
);

    localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);

    logic [DIV_W-1:0] div_reg;
    logic [1:0]       col_reg;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            div_reg <= '0;
            col_reg <= '0;
        end else if (sample_en) begin
            div_reg <= '0;
            col_reg <= col_reg + 2'd1;   // 2-bit index wraps 3 -> 0
        end else begin
            div_reg <= div_reg + 1'b1;
        end
    end

    assign sample_en = (div_reg == DIV_LAST);
    assign scan_end  = sample_en && (col_reg == 2'(NUM_COLS - 1));
    assign col       = col_reg;

    generate
        for (genvar gi = 0; gi < NUM_COLS; gi++) begin : g_col_drive
            assign col_out[gi] = (col_reg != 2'(gi));
        end
    endgenerate

endmodule

// File: rtl/keypad_scanner.sv
// keypad_scanner: scans a 4x4 active-low keypad, debounces presses and
// releases, and emits one shift_valid strobe per accepted press.
//   clk      system clock
//   rst_n    synchronous active-low reset
//   row_in   keypad rows, active-low, asynchronous to clk
//   col_out  active-low one-hot column drive
//   key_bus  master side of the key-entry bus (key_code, shift_valid,
//            key_pressed)
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV       = 1000,
    parameter int DEBOUNCE_SCANS = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NUM_ROWS-1:0]  row_in,
    output logic [NUM_COLS-1:0]  col_out,
    keypad_scanner_if.master     key_bus
);

    localparam int CNT_W = $clog2(DEBOUNCE_SCANS + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_SCANS);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [1:0] col;
    logic       sample_en;
    logic       scan_end;

    keypad_col_scan #(
        .SCAN_DIV (SCAN_DIV)
    ) u_col_scan (
        .clk       (clk),
        .rst_n     (rst_n),
        .col_out   (col_out),
        .col       (col),
        .sample_en (sample_en),
        .scan_end  (scan_end)
    );

    // Two-flop synchronizer; idle rows read as all-high.
    logic [NUM_ROWS-1:0] sync1_reg;
    logic [NUM_ROWS-1:0] sync2_reg;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1_reg <= '1;
            sync2_reg <= '1;
        end else begin
            sync1_reg <= row_in;
            sync2_reg <= sync1_reg;
        end
    end

    // Lowest-index low row wins within the slot: scanning downward lets the
    // lowest row overwrite any higher one.
    logic       slot_hit;
    logic [1:0] slot_row;

    always_comb begin
        slot_hit = 1'b0;
        slot_row = 2'd0;
        for (int r = NUM_ROWS - 1; r >= 0; r--) begin
            if (!sync2_reg[r]) begin
                slot_hit = 1'b1;
                slot_row = 2'(r);
            end
        end
    end

    // Scan accumulator: keeps the first column that produced a hit. At scan
    // end the column 3 slot is folded in combinationally, so the result is
    // complete on that very cycle.
    logic             acc_hit_reg;
    logic [KEY_W-1:0] acc_code_reg;
    logic             scan_found;
    logic [KEY_W-1:0] scan_code;

    assign scan_found = acc_hit_reg | slot_hit;
    assign scan_code  = acc_hit_reg ? acc_code_reg : key_code_of(slot_row, col);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc_hit_reg  <= 1'b0;
            acc_code_reg <= '0;
        end else if (scan_end) begin
            acc_hit_reg  <= 1'b0;
            acc_code_reg <= '0;
        end else if (sample_en && !acc_hit_reg && slot_hit) begin
            acc_hit_reg  <= 1'b1;
            acc_code_reg <= key_code_of(slot_row, col);
        end
    end

    // Debounce FSM; it only moves on scan_end.
    state_t           state_reg,    state_next;
    logic [KEY_W-1:0] cand_reg,     cand_next;
    logic [CNT_W-1:0] cnt_reg,      cnt_next;
    logic [KEY_W-1:0] key_code_reg, key_code_next;
    logic             shift_valid_reg, shift_valid_next;
    logic [CNT_W-1:0] cnt_inc;

    assign cnt_inc = cnt_reg + CNT_ONE;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg       <= IDLE;
            cand_reg        <= '0;
            cnt_reg         <= '0;
            key_code_reg    <= '0;
            shift_valid_reg <= 1'b0;
        end else begin
            state_reg       <= state_next;
            cand_reg        <= cand_next;
            cnt_reg         <= cnt_next;
            key_code_reg    <= key_code_next;
            shift_valid_reg <= shift_valid_next;
        end
    end

    always_comb begin
        state_next       = state_reg;
        cand_next        = cand_reg;
        cnt_next         = cnt_reg;
        key_code_next    = key_code_reg;
        shift_valid_next = 1'b0;

        if (scan_end) begin
            case (state_reg)
                IDLE: begin
                    if (scan_found) begin
                        if (DEBOUNCE_SCANS == 1) begin
                            state_next       = PRESSED;
                            key_code_next    = scan_code;
                            shift_valid_next = 1'b1;
                            cnt_next         = '0;
                        end else begin
                            state_next = DEBOUNCE;
                            cand_next  = scan_code;
                            cnt_next   = CNT_ONE;
                        end
                    end
                end
                DEBOUNCE: begin
                    if (!scan_found) begin
                        state_next = IDLE;
                        cnt_next   = '0;
                    end else if (scan_code == cand_reg) begin
                        if (cnt_inc >= CNT_MAX) begin
                            state_next       = PRESSED;
                            key_code_next    = cand_reg;
                            shift_valid_next = 1'b1;
                            cnt_next         = '0;
                        end else begin
                            cnt_next = cnt_inc;
                        end
                    end else begin
                        cand_next = scan_code;
                        cnt_next  = CNT_ONE;
                    end
                end
                PRESSED: begin
                    // Held or additional keys keep us here without re-strobing.
                    if (!scan_found) begin
                        if (DEBOUNCE_SCANS == 1) begin
                            state_next = IDLE;
                            cnt_next   = '0;
                        end else begin
                            state_next = RELEASE;
                            cnt_next   = CNT_ONE;
                        end
                    end
                end
                RELEASE: begin
                    if (!scan_found) begin
                        if (cnt_inc >= CNT_MAX) begin
                            state_next = IDLE;
                            cnt_next   = '0;
                        end else begin
                            cnt_next = cnt_inc;
                        end
                    end else begin
                        // Release glitch: back to the held key, no new strobe.
                        state_next = PRESSED;
                        cnt_next   = '0;
                    end
                end
                default: begin
                    state_next = IDLE;
                    cnt_next   = '0;
                end
            endcase
        end
    end

    assign key_bus.key_code    = key_code_reg;
    assign key_bus.shift_valid = shift_valid_reg;
    assign key_bus.key_pressed = (state_reg == PRESSED) || (state_reg == RELEASE);

endmodule

// File: tb/tb_keypad_scanner.sv
// tb_keypad_scanner: self-checking bench for keypad_scanner with
// SCAN_DIV=4, DEBOUNCE_SCANS=2 (16-cycle scan). A behavioural keypad pulls a
// row low whenever a pressed key sits in the driven column. Expected key
// codes are queued when a press is applied and popped when a strobe appears.
module tb_keypad_scanner;

    localparam int SCAN_DIV       = 4;
    localparam int DEBOUNCE_SCANS = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  row_in;
    logic [3:0]  col_out;
    logic [15:0] keys;

    always #5 clk = ~clk;

    keypad_scanner_if kbus ();

    keypad_scanner #(
        .SCAN_DIV       (SCAN_DIV),
        .DEBOUNCE_SCANS (DEBOUNCE_SCANS)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .row_in  (row_in),
        .col_out (col_out),
        .key_bus (kbus)
    );

    // Keypad model: key 4*r+c shorts row r to column c.
    always_comb begin
        row_in = 4'hF;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (keys[4*r + c] && !col_out[c]) row_in[r] = 1'b0;
            end
        end
    end

    int         checks = 0;
    int         passes = 0;
    logic [3:0] exp_q[$];
    logic [3:0] exp_pop;
    logic       prev_sv = 1'b0;

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act == req) passes++;
        else $display("FAIL %s: got %0d, required %0d", name, act, req);
    endtask

    // Scoreboard monitor, sampled 1 time unit after the active edge.
    always @(posedge clk) begin
        #1;
        if (kbus.shift_valid) begin
            if (prev_sv) check("strobe_single_cycle", 1, 0);
            if (exp_q.size() == 0) begin
                checks++;
                $display("FAIL unexpected_strobe: got key_code %0d, required no strobe",
                         kbus.key_code);
            end else begin
                exp_pop = exp_q.pop_front();
                check("strobe_code", int'(kbus.key_code), int'(exp_pop));
            end
        end
        prev_sv = kbus.shift_valid;
    end

    // Advance (from a negedge) to the negedge inside the first cycle of the
    // next scan, i.e. the first cycle with column 0 driven after column 3.
    task automatic next_scan();
        int n = 0;
        while (col_out != 4'b0111 && n < 100) begin
            @(negedge clk);
            n++;
        end
        while (col_out != 4'b1110 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) begin
            checks++;
            $display("FAIL scan_align: got timeout after %0d cycles, required scan start", n);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_col_out"},     int'(col_out),          14);
        check({tag, "_key_code"},    int'(kbus.key_code),    0);
        check({tag, "_shift_valid"}, int'(kbus.shift_valid), 0);
        check({tag, "_key_pressed"}, int'(kbus.key_pressed), 0);
    endtask

    typedef struct {
        logic [15:0] keys;
        int          scans;
        bit          strobe;
        logic [3:0]  code;
        bit          exp_pressed;
        logic [3:0]  exp_code;
    } vec_t;

    vec_t tbl[15];

    initial begin
        int n;

        // keys, scans held, strobe expected, its code, then state after
        tbl[0]  = '{16'h0000, 1, 1'b0, 4'd0,  1'b1, 4'd9};   // release glitch
        tbl[1]  = '{16'h0200, 1, 1'b0, 4'd0,  1'b1, 4'd9};   // repress 9: no strobe
        tbl[2]  = '{16'h0000, 2, 1'b0, 4'd0,  1'b0, 4'd9};   // full release
        tbl[3]  = '{16'h0010, 3, 1'b1, 4'd4,  1'b1, 4'd4};   // new press 4
        tbl[4]  = '{16'h0000, 2, 1'b0, 4'd0,  1'b0, 4'd4};
        tbl[5]  = '{16'h0020, 1, 1'b0, 4'd0,  1'b0, 4'd4};   // bounce on 5
        tbl[6]  = '{16'h0000, 1, 1'b0, 4'd0,  1'b0, 4'd4};
        tbl[7]  = '{16'h0020, 1, 1'b0, 4'd0,  1'b0, 4'd4};
        tbl[8]  = '{16'h0000, 1, 1'b0, 4'd0,  1'b0, 4'd4};
        tbl[9]  = '{16'h0020, 3, 1'b1, 4'd5,  1'b1, 4'd5};   // 5 settles
        tbl[10] = '{16'h0000, 2, 1'b0, 4'd0,  1'b0, 4'd5};
        tbl[11] = '{16'h0008, 1, 1'b0, 4'd0,  1'b0, 4'd5};   // 3 briefly
        tbl[12] = '{16'h1000, 3, 1'b1, 4'd12, 1'b1, 4'd12};  // then 12 stable
        tbl[13] = '{16'h0000, 2, 1'b0, 4'd0,  1'b0, 4'd12};
        tbl[14] = '{16'h4040, 3, 1'b1, 4'd6,  1'b1, 4'd6};   // 6 and 14 together

        // Reset held with key 4 (row 1, column 0) down.
        rst_n = 1'b0;
        keys  = 16'h0010;
        repeat (6) begin
            @(negedge clk);
            check_reset_outputs("in_reset");
        end

        // Released: this cycle is the start of the first scan.
        rst_n = 1'b1;
        exp_q.push_back(4'd4);
        next_scan();
        check("post_reset_debouncing_pressed", int'(kbus.key_pressed), 0);
        next_scan();
        check("post_reset_pressed", int'(kbus.key_pressed), 1);
        check("post_reset_code",    int'(kbus.key_code),    4);
        check("post_reset_drained", exp_q.size(),           0);

        keys = 16'h0000;
        next_scan();
        next_scan();
        check("release_pressed", int'(kbus.key_pressed), 0);

        // Clean press of key 9 (row 2, column 1) applied at a scan start.
        // Counting the scan-start cycle as 1, the strobe lands on cycle 33.
        next_scan();
        keys = 16'h0200;
        exp_q.push_back(4'd9);
        n = 1;
        while (!kbus.shift_valid && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("press_latency", n, 33);
        check("press_pressed_at_strobe", int'(kbus.key_pressed), 1);
        next_scan();
        next_scan();
        next_scan();
        check("press_held_pressed", int'(kbus.key_pressed), 1);
        check("press_held_code",    int'(kbus.key_code),    9);
        check("press_drained",      exp_q.size(),           0);

        for (int i = 0; i < 15; i++) begin
            keys = tbl[i].keys;
            if (tbl[i].strobe) exp_q.push_back(tbl[i].code);
            for (int s = 0; s < tbl[i].scans; s++) next_scan();
            check($sformatf("v%0d_pressed", i), int'(kbus.key_pressed), int'(tbl[i].exp_pressed));
            check($sformatf("v%0d_code", i),    int'(kbus.key_code),    int'(tbl[i].exp_code));
            check($sformatf("v%0d_drained", i), exp_q.size(),           0);
        end

        // Reset in the middle of a held press (keys 6 and 14 still down).
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check_reset_outputs("mid_reset");
        end
        rst_n = 1'b1;
        exp_q.push_back(4'd6);
        next_scan();
        check("mid_reset_debouncing_pressed", int'(kbus.key_pressed), 0);
        next_scan();
        check("mid_reset_pressed", int'(kbus.key_pressed), 1);
        check("mid_reset_code",    int'(kbus.key_code),    6);
        check("mid_reset_drained", exp_q.size(),           0);

        keys = 16'h0000;
        repeat (4) @(negedge clk);
        check("final_queue_empty", exp_q.size(), 0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/keypad_scanner.md
# keypad_scanner

Scans a 4x4 active-low matrix keypad, debounces each press and emits a 4-bit key code with a single-cycle `shift_valid` strobe. It is the producer side of the key-entry path. `key_code`/`shift_valid` connect directly to the shift-register/adder stage's `key_in`/`shift_valid` inputs, so that each debounced press shifts exactly one operand.

## Interface
- `SCAN_DIV`, 1000: clock cycles each column stays driven; must be >= 4.
- `DEBOUNCE_SCANS`, 4: consecutive identical full scans required to accept a press or a release; must be >= 1.
- `clk`  in  1  system clock; all logic on the rising edge.
- `rst_n`  in  1  reset, synchronous, active-low.
- `row_in`  in  4  keypad rows, active-low, externally pulled up, asynchronous to `clk`.
- `col_out`  out  4  column drive, active-low one-hot.
- `key_code`  out  4  last accepted key, `4*row + col`.
- `shift_valid`  out  1  one-cycle strobe per accepted press.
- `key_pressed`  out  1  high while a debounced key is held (states PRESSED and RELEASE).

## Operation
- **Row synchronizer:** `row_in` passes through a 2-flop synchronizer; both stages reset to 4'b1111.
- **Column scan:** a divider counts 0..SCAN_DIV-1 per column, and a column index advances 0..3 and wraps to 0.
  - `col_out` = ~(1 << col).
  - The synchronized rows are sampled on divider count SCAN_DIV-1 (the last cycle of the slot).
- **Per-scan result, accumulated over columns 0..3:**
  - Within a slot, the lowest-index low row wins.
  - Across the scan, the first column with a hit wins.
  - The result is "none" or one code. It is evaluated at the end of column 3 ("scan end").
- **FSM:** states IDLE, DEBOUNCE, PRESSED, RELEASE, with a candidate register `cand` and a counter `cnt`. Transitions happen only at scan end; all other cycles hold.
  - IDLE:
    - code X found -> DEBOUNCE, `cand`=X, `cnt`=1.
    - none -> stay.
  - DEBOUNCE:
    - same code -> `cnt`+1.
    - When `cnt` reaches DEBOUNCE_SCANS -> PRESSED, `key_code`<=`cand`, `shift_valid` pulse.
    - DEBOUNCE_SCANS=1 accepts directly from IDLE on the first scan.
    - different code Y -> restart with `cand`=Y, `cnt`=1.
    - none -> IDLE.
  - PRESSED:
    - none -> RELEASE, `cnt`=1.
    - DEBOUNCE_SCANS=1 goes directly to IDLE.
    - any key -> stay. Holding a key or adding keys never repeats the strobe.
  - RELEASE:
    - none -> `cnt`+1; reaching DEBOUNCE_SCANS -> IDLE.
    - any key -> PRESSED, `cnt`=0, no strobe.
- **Outputs:**
  - `key_code` holds its value until the next accepted press.
  - `shift_valid` is never high for two consecutive cycles.

## Timing
- **Reset values:** `col_out`=4'b1110, `key_code`=0, `shift_valid`=0, `key_pressed`=0. State IDLE, divider 0, column 0, `cnt`=0, scan accumulator empty.
- **Reset mid-operation:** aborts any debounce or press. No strobe is issued for a key already held at reset release until a full DEBOUNCE_SCANS of identical scans completes.
- **Scan period:** 4*SCAN_DIV cycles.
- **Synchronizer latency:** 2 cycles. A row change is visible at a sample point only if it is stable at least 2 cycles before the sample.
- **Strobe timing:** `key_code` updates and `shift_valid` goes high in the cycle after the accepting scan end. `key_pressed` rises in the same cycle.
- **Press latency:** from a key stable before scan start to the strobe is DEBOUNCE_SCANS*4*SCAN_DIV + 1 cycles. The worst case adds one scan period.
- **Release latency:** `key_pressed` falls one cycle after the scan end that completes the release count.

## Structure
- **Package `keypad_pkg`:**
  - the FSM state enum (IDLE, DEBOUNCE, PRESSED, RELEASE);
  - constants NUM_ROWS=4 and NUM_COLS=4;
  - a code function `key_code_of(row, col)` returning `4*row + col`.
- **Sub-module `keypad_col_scan`:** divider, column index, `col_out` drive, and `sample_en`/`scan_end` strobes.
- **Top `keypad_scanner`:** synchronizer, scan accumulator, FSM and outputs.

## Test plan
Bench uses SCAN_DIV=4, DEBOUNCE_SCANS=2 (scan period 16 cycles).
- **Reset:** hold `rst_n`=0 with row 1 low -> `col_out`=4'b1110, `key_code`=0, `shift_valid`=0 throughout; after release the FSM starts from IDLE.
- **Clean press:** row 2 low while column 1 is driven, held 5 scans -> exactly one `shift_valid` pulse with `key_code`=9, 33 cycles after the first scan start that sees it; `key_pressed`=1.
- **Bounce:** key 5 alternating present/absent every scan for 4 scans, then held -> no strobe during bouncing; one strobe with `key_code`=5 after 2 stable scans.
- **Change during debounce:** key 3 for 1 scan, then key 12 stable -> single strobe with `key_code`=12, no strobe for 3.
- **Release glitch and repress:**
  - Release key 9 for 1 scan, then press again -> no second strobe, `key_pressed` stays 1.
  - Release for 2 scans -> `key_pressed`=0.
  - A new press of 4 -> strobe with `key_code`=4.
- **Multiple keys and mid-press reset:**
  - Keys 6 and 14 held together -> `key_code`=6 (lowest row in the first hit column).
  - Assert `rst_n` mid-press -> outputs return to reset values, and a fresh strobe follows 2 stable scans after reset release.
